ram_dxw_rw_arb: RTL and testbench

- Shares one read/write port of the dual-port RAM (registered read, 1-cycle latency) between NREQ requesters, using round-robin arbitration.
- After reset, runs a clear sequence that writes INIT_VALUE to every word before any request is accepted.
- Sits between client logic (e.g. cache fill, debug access) and one RAM port. The other RAM port stays owned by the instantiating block.

---
 rtl/ram_dxw_rw_arb_pkg.sv | 16 +
 rtl/ram_dxw_rw_arb_rr_arbiter.sv | 45 ++++
 rtl/ram_dxw_rw_arb.sv | 124 ++++++++++++
 tb/tb_ram_dxw_rw_arb.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_dxw_rw_arb_pkg.sv
// Shared types and helpers for the round-robin RAM port arbiter.
package ram_arb_pkg;

  localparam int NREQ_MAX = 8;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } arb_state_e;

  // Address width for a power-of-two RAM depth.
  function automatic int abits_f(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/ram_dxw_rw_arb_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from a rotating pointer.
// The pointer moves past the winner only when advance is asserted.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_gidx;
  logic          w_found;

  // Pick the first requester at or after the pointer, wrapping modulo N.
  always_comb begin
    int idx;
    grant   = '0;
    w_gidx  = '0;
    w_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!w_found && req[idx]) begin
        grant[idx] = 1'b1;
        w_gidx     = PW'(idx);
        w_found    = 1'b1;
      end
    end
  end

  // Rotate the pointer to one past the winner on a transfer; hold otherwise.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= '0;
    end else if (advance && w_found) begin
      r_ptr <= (w_gidx == PW'(N - 1)) ? '0 : w_gidx + 1'b1;
    end
  end

endmodule

// File: rtl/ram_dxw_rw_arb.sv
// Shares one RAM read/write port between NREQ requesters with round-robin
// arbitration. After reset the whole RAM is cleared to INIT_VALUE before
// any request is accepted.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_INIT | writing INIT_VALUE to address r_init_cnt, one word/cycle
//   ST_RUN  | arbitrating requesters onto the RAM port
module ram_dxw_rw_arb
  import ram_arb_pkg::*;
#(
  parameter int                DEPTH         = 256,
  parameter int                WIDTH         = 8,
  parameter int                NREQ          = 3,
  parameter bit                INIT_ON_RESET = 1'b1,
  parameter logic [WIDTH-1:0]  INIT_VALUE    = '0,
  localparam int               ABITS         = abits_f(DEPTH)
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ-1:0]         req_wr,
  input  logic [NREQ*ABITS-1:0]   req_addr,
  input  logic [NREQ*WIDTH-1:0]   req_wdata,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [WIDTH-1:0]        rsp_rdata,
  output logic                    init_done,
  output logic [ABITS-1:0]        ram_address,
  output logic                    ram_wren,
  output logic [WIDTH-1:0]        ram_data,
  input  logic [WIDTH-1:0]        ram_q
);

  arb_state_e        r_state;
  logic [ABITS-1:0]  r_init_cnt;
  logic [NREQ-1:0]   r_rsp_valid;
  logic [ABITS-1:0]  r_hold_addr;
  logic [WIDTH-1:0]  r_hold_data;

  logic              w_run;
  logic [NREQ-1:0]   w_arb_req;
  logic [NREQ-1:0]   w_grant;
  logic              w_sel_wr;
  logic [ABITS-1:0]  w_sel_addr;
  logic [WIDTH-1:0]  w_sel_data;

  // Gating with reset_n keeps every output quiet while reset is held,
  // even when the reset state is ST_RUN.
  assign w_run     = reset_n && (r_state == ST_RUN);
  assign w_arb_req = req_valid & {NREQ{w_run}};
  assign req_ready = w_grant;
  assign init_done = w_run;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = ram_q;

  rr_arbiter #(.N(NREQ)) u_arb (
    .clock   (clock),
    .reset_n (reset_n),
    .req     (w_arb_req),
    .advance (|w_arb_req),
    .grant   (w_grant)
  );

  // Select the granted requester's command fields.
  always_comb begin
    w_sel_wr   = 1'b0;
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_sel_wr   = req_wr[i];
        w_sel_addr = req_addr[i*ABITS +: ABITS];
        w_sel_data = req_wdata[i*WIDTH +: WIDTH];
      end
    end
  end

  // Drive the RAM port: clear sequence, granted access, or idle hold.
  always_comb begin
    if (r_state == ST_INIT) begin
      ram_wren    = reset_n;
      ram_address = r_init_cnt;
      ram_data    = INIT_VALUE;
    end else if (|w_grant) begin
      ram_wren    = w_sel_wr;
      ram_address = w_sel_addr;
      ram_data    = w_sel_data;
    end else begin
      ram_wren    = 1'b0;
      ram_address = r_hold_addr;
      ram_data    = r_hold_data;
    end
  end

  // Clear-sequence FSM: one word per cycle, then hand over to arbitration.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= INIT_ON_RESET ? ST_INIT : ST_RUN;
      r_init_cnt <= '0;
    end else if (r_state == ST_INIT) begin
      r_init_cnt <= r_init_cnt + 1'b1;
      if (r_init_cnt == ABITS'(DEPTH - 1)) r_state <= ST_RUN;
    end
  end

  // Read response fires one cycle after an accepted read (RAM latency).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_rsp_valid <= '0;
    else          r_rsp_valid <= w_grant & ~req_wr;
  end

  // Remember the last driven address/data so an idle port does not toggle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_hold_addr <= '0;
      r_hold_data <= '0;
    end else begin
      r_hold_addr <= ram_address;
      r_hold_data <= ram_data;
    end
  end

endmodule

// File: tb/tb_ram_dxw_rw_arb.sv
// Scoreboard bench for ram_dxw_rw_arb with a behavioural RAM and
// a reference model of arbitration, clearing and read responses.
module tb_ram_dxw_rw_arb;

  localparam int DEPTH = 256;
  localparam int WIDTH = 8;
  localparam int NREQ  = 3;
  localparam int ABITS = 8;

  logic                  clock = 1'b0;
  logic                  reset_n;
  logic [NREQ-1:0]       req_valid, req_ready, req_wr, rsp_valid;
  logic [NREQ*ABITS-1:0] req_addr;
  logic [NREQ*WIDTH-1:0] req_wdata;
  logic [WIDTH-1:0]      rsp_rdata, ram_data, ram_q;
  logic [ABITS-1:0]      ram_address;
  logic                  ram_wren, init_done;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int init_cnt = 0;

  ram_dxw_rw_arb #(.DEPTH(DEPTH), .WIDTH(WIDTH), .NREQ(NREQ),
                   .INIT_ON_RESET(1'b1), .INIT_VALUE(8'h00)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .init_done(init_done),
    .ram_address(ram_address), .ram_wren(ram_wren), .ram_data(ram_data),
    .ram_q(ram_q)
  );

  always #5 clock = ~clock;

  // Behavioural RAM port: write-first, registered read; starts with garbage.
  logic [WIDTH-1:0] ram_mem [DEPTH];
  bit mem_filled = 1'b0;
  always @(posedge clock) begin
    if (!mem_filled) begin
      for (int i = 0; i < DEPTH; i++) ram_mem[i] <= 8'($urandom);
      mem_filled <= 1'b1;
    end else begin
      if (ram_wren) ram_mem[ram_address] <= ram_data;
      ram_q <= ram_wren ? ram_data : ram_mem[ram_address];
    end
  end

  // Rising edges seen since reset was released.
  always @(posedge clock) begin
    if (!reset_n) init_cnt = 0;
    else if (init_cnt < 100000) init_cnt = init_cnt + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model state.
  typedef struct { int idx; logic [WIDTH-1:0] data; int due; } rsp_t;
  rsp_t              sb_q[$];
  logic [WIDTH-1:0]  m_mem [DEPTH];
  int                m_ptr = 0;
  bit                m_known = 1'b0;
  logic [ABITS-1:0]  m_last_addr;
  logic [WIDTH-1:0]  m_last_data;

  // Monitor/model: evaluated mid-cycle while inputs are stable.
  always @(negedge clock) begin
    int g;
    logic [NREQ-1:0] exp_ready;
    logic [ABITS-1:0] ga;
    logic [WIDTH-1:0] gd;
    rsp_t e;
    cyc++;
    if (!reset_n) begin
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_init_done", 32'(init_done), 0);
      chk("rst_ram_wren", 32'(ram_wren), 0);
      sb_q.delete();
      m_ptr = 0;
      m_known = 1'b0;
    end else begin
      if (init_cnt == DEPTH) begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
        m_known = 1'b1;
        m_last_addr = ABITS'(DEPTH - 1);
        m_last_data = 8'h00;
      end
      chk("init_done", 32'(init_done), 32'(init_cnt >= DEPTH));
      g = -1;
      if (init_cnt >= DEPTH) begin
        for (int k = 0; k < NREQ; k++)
          if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
      end else begin
        chk("init_wren", 32'(ram_wren), 1);
        chk("init_addr", 32'(ram_address), 32'(init_cnt));
        chk("init_data", 32'(ram_data), 0);
      end
      exp_ready = (g >= 0) ? NREQ'(1 << g) : '0;
      chk("req_ready", 32'(req_ready), 32'(exp_ready));

      if (rsp_valid != 0) begin
        if (sb_q.size() == 0) begin
          chk("rsp_unexpected", 32'(rsp_valid), 0);
        end else begin
          e = sb_q.pop_front();
          chk("rsp_valid", 32'(rsp_valid), 32'(1 << e.idx));
          chk("rsp_rdata", 32'(rsp_rdata), 32'(e.data));
          chk("rsp_latency", 32'(cyc), 32'(e.due));
        end
      end else if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
        e = sb_q.pop_front();
        chk("rsp_missing", 0, 1);
      end

      if (init_cnt >= DEPTH) begin
        if (g >= 0) begin
          ga = req_addr[g*ABITS +: ABITS];
          gd = req_wdata[g*WIDTH +: WIDTH];
          chk("ram_address", 32'(ram_address), 32'(ga));
          chk("ram_wren", 32'(ram_wren), 32'(req_wr[g]));
          chk("ram_data", 32'(ram_data), 32'(gd));
          if (req_wr[g]) m_mem[ga] = gd;
          else sb_q.push_back('{idx: g, data: m_mem[ga], due: cyc + 1});
          m_last_addr = ga;
          m_last_data = gd;
          m_ptr = (g + 1) % NREQ;
        end else begin
          chk("idle_wren", 32'(ram_wren), 0);
          if (m_known) begin
            chk("idle_addr_hold", 32'(ram_address), 32'(m_last_addr));
            chk("idle_data_hold", 32'(ram_data), 32'(m_last_data));
          end
        end
      end
    end
  end

  // Called at posedge+1; leaves the caller at posedge+1 again.
  task automatic wait_init(input int budget);
    int n = 0;
    while (!init_done && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (!init_done) begin
      n_vec++; n_err++;
      $display("FAIL wait_init: init_done not seen within %0d cycles", budget);
    end
    @(posedge clock); #1;
  endtask

  task automatic issue(input int r, input bit w, input logic [7:0] a, input logic [7:0] d);
    bit got = 1'b0;
    req_wr[r] = w;
    req_addr[r*ABITS +: ABITS] = a;
    req_wdata[r*WIDTH +: WIDTH] = d;
    req_valid[r] = 1'b1;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clock);
      got = req_ready[r];
      @(posedge clock); #1;
    end
    req_valid[r] = 1'b0;
    if (!got) begin
      n_vec++; n_err++;
      $display("FAIL issue_timeout: requester %0d not granted, actual 0 required 1", r);
    end
  endtask

  task automatic new_req(input int r);
    req_wr[r] = 1'($urandom_range(0, 1));
    req_addr[r*ABITS +: ABITS] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
    req_wdata[r*WIDTH +: WIDTH] = 8'($urandom);
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    logic [NREQ-1:0] g;
    reset_n = 1'b0; req_valid = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
    // Requests pending across the whole clear sequence must not be accepted.
    for (int r = 0; r < NREQ; r++) begin
      req_wr[r] = 1'b0;
      req_addr[r*ABITS +: ABITS] = 8'(r * 85);
    end
    req_valid = '1;
    repeat (3) @(posedge clock); #1;
    reset_n = 1'b1;
    wait_init(400);
    idle(2);

    // Cleared words at both ends.
    issue(0, 1'b0, 8'h00, 8'h00);
    issue(0, 1'b0, 8'hFF, 8'h00);
    idle(2);

    // All requesters continuously reading.
    for (int r = 0; r < NREQ; r++) begin req_wr[r] = 1'b0; req_addr[r*ABITS +: ABITS] = 8'($urandom); end
    req_valid = '1;
    repeat (6) begin
      @(negedge clock); g = req_ready;
      @(posedge clock); #1;
      for (int r = 0; r < NREQ; r++) if (g[r]) req_addr[r*ABITS +: ABITS] = 8'($urandom);
    end
    idle(2);

    // Write then read of the same word on consecutive cycles.
    issue(0, 1'b1, 8'h10, 8'hA5);
    issue(1, 1'b0, 8'h10, 8'h00);
    idle(2);

    // Back-to-back reads from a single requester.
    for (int i = 1; i <= 4; i++) issue(2, 1'b1, 8'(i), 8'(i * 8'h11));
    for (int i = 1; i <= 4; i++) issue(2, 1'b0, 8'(i), 8'h00);
    idle(2);

    // Randomised traffic honouring hold-until-ready.
    for (int r = 0; r < NREQ; r++) new_req(r);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock); g = req_ready;
      @(posedge clock); #1;
      for (int r = 0; r < NREQ; r++) begin
        if (req_valid[r] && !g[r]) begin
          if ($urandom_range(0, 15) == 0) req_valid[r] = 1'b0;
        end else begin
          new_req(r);
          req_valid[r] = ($urandom_range(0, 9) < 6);
        end
      end
    end
    idle(3);

    // Reset in the middle of the clear sequence.
    reset_n = 1'b0; repeat (3) @(posedge clock); #1; reset_n = 1'b1;
    for (int n = 0; n < 200 && init_cnt < 100; n++) begin @(posedge clock); #1; end
    reset_n = 1'b0; repeat (3) @(posedge clock); #1; reset_n = 1'b1;
    wait_init(400);
    idle(1);

    // Reset right after a read is accepted drops its response.
    issue(1, 1'b0, 8'h10, 8'h00);
    reset_n = 1'b0;
    repeat (3) @(posedge clock); #1; reset_n = 1'b1;
    wait_init(400);
    for (int r = 0; r < NREQ; r++) req_wr[r] = 1'b0;
    req_valid = '1;
    @(negedge clock);
    chk("first_grant_after_reset", 32'(req_ready), 32'b001);
    @(posedge clock); #1;
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
